// File: rtl/vr_wheel_gen.sv
// Crank-wheel emulator: N-minus-M missing-tooth VR pulse train with per-tooth
// index, gap and revolution markers for driving and checking the hwag decoder.
module vr_wheel_gen #(
    parameter int TOOTH_COUNT = 60,
    parameter int GAP_TEETH   = 2,
    parameter int PERIOD_W    = 16,
    parameter int TOOTH_W     = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [PERIOD_W-1:0] period,
    output logic                vr_out,
    output logic [TOOTH_W-1:0]  tooth_num,
    output logic                gap,
    output logic                rev,
    output logic                cfg_err
);

    localparam logic [TOOTH_W-1:0]  LAST_TOOTH = TOOTH_W'(TOOTH_COUNT - 1);
    localparam logic [TOOTH_W-1:0]  GAP_START  = TOOTH_W'(TOOTH_COUNT - GAP_TEETH);
    localparam logic [PERIOD_W-1:0] MIN_PER    = PERIOD_W'(2);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_e;

    state_e                state_q, state_d;
    logic [PERIOD_W-1:0]   hc_q, hc_d;
    logic [PERIOD_W-1:0]   per_q, per_d;
    logic [TOOTH_W-1:0]    tooth_q, tooth_d;
    logic                  vr_q, vr_d;
    logic                  gap_q, gap_d;
    logic                  rev_q, rev_d;
    logic                  cfg_err_q, cfg_err_d;

    logic                  half_done;
    logic                  period_ok;
    logic [TOOTH_W-1:0]    next_tooth;
    logic                  next_gap;

    // hc never exceeds per_q-1, so a full-scale period cannot wrap the counter
    assign half_done  = (hc_q == per_q - PERIOD_W'(1));
    assign period_ok  = (period >= MIN_PER);
    assign next_tooth = (tooth_q == LAST_TOOTH) ? '0 : tooth_q + TOOTH_W'(1);
    assign next_gap   = (next_tooth >= GAP_START);

    always_comb begin
        state_d   = state_q;
        hc_d      = hc_q;
        per_d     = per_q;
        tooth_d   = tooth_q;
        vr_d      = vr_q;
        gap_d     = gap_q;
        rev_d     = 1'b0;
        cfg_err_d = cfg_err_q;

        case (state_q)
            IDLE: begin
                hc_d    = '0;
                vr_d    = 1'b0;
                tooth_d = '0;
                gap_d   = 1'b0;
                if (en) begin
                    if (period_ok) begin
                        per_d     = period;
                        rev_d     = 1'b1;
                        vr_d      = 1'b1;
                        cfg_err_d = 1'b0;
                        state_d   = HIGH;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            HIGH: begin
                if (half_done) begin
                    hc_d    = '0;
                    vr_d    = 1'b0;
                    state_d = LOW;
                end else begin
                    hc_d = hc_q + PERIOD_W'(1);
                end
            end
            LOW: begin
                if (half_done) begin
                    hc_d  = '0;
                    per_d = period;
                    if (period_ok) begin
                        tooth_d   = next_tooth;
                        gap_d     = next_gap;
                        vr_d      = ~next_gap;
                        rev_d     = (next_tooth == '0);
                        cfg_err_d = 1'b0;
                        state_d   = HIGH;
                    end else begin
                        // a bad relatch parks the wheel; IDLE shows tooth 0, no rev
                        tooth_d   = '0;
                        gap_d     = 1'b0;
                        vr_d      = 1'b0;
                        cfg_err_d = 1'b1;
                        state_d   = IDLE;
                    end
                end else begin
                    hc_d = hc_q + PERIOD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // en low overrides everything, including a coincident tooth boundary
        if (!en) begin
            state_d   = IDLE;
            hc_d      = '0;
            tooth_d   = '0;
            vr_d      = 1'b0;
            gap_d     = 1'b0;
            rev_d     = 1'b0;
            cfg_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            hc_q      <= '0;
            per_q     <= '0;
            tooth_q   <= '0;
            vr_q      <= 1'b0;
            gap_q     <= 1'b0;
            rev_q     <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hc_q      <= hc_d;
            per_q     <= per_d;
            tooth_q   <= tooth_d;
            vr_q      <= vr_d;
            gap_q     <= gap_d;
            rev_q     <= rev_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign vr_out    = vr_q;
    assign tooth_num = tooth_q;
    assign gap       = gap_q;
    assign rev       = rev_q;
    assign cfg_err   = cfg_err_q;

endmodule

// File: doc/vr_wheel_gen.md
Name: vr_wheel_gen

Overview:
- Crank-wheel emulator: generates the VR tooth pulse train (N-minus-M missing-tooth wheel) that feeds hwag vr_in.
- It is the transmitter end of the vr_in interface. It replaces the free-running square-wave stimulus in benches.
- It also serves as an on-chip self-test source.
- It emits per-tooth index, gap and revolution markers, so the hwag decoder can be checked tooth-for-tooth.

Parameters:
- TOOTH_COUNT, 60, tooth slots per revolution, including missing ones (>= GAP_TEETH+2).
- GAP_TEETH, 2, missing teeth at the end of each revolution (>= 1).
- PERIOD_W, 16, width of the half-tooth period value.
- TOOTH_W, 6, width of tooth_num (must hold TOOTH_COUNT-1).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  run enable; level-sensitive.
- period  input  PERIOD_W  half-tooth duration in clk cycles.
- vr_out  output  1  emulated VR tooth signal (registered).
- tooth_num  output  TOOTH_W  index of the current tooth slot, 0..TOOTH_COUNT-1.
- gap  output  1  high while the current slot is a missing tooth.
- rev  output  1  one-clk pulse at the start of tooth 0.
- cfg_err  output  1  high while en=1 and the latched period is < 2.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. vr_out, tooth_num, gap, rev, cfg_err and all counters are 0.
- State machine states: IDLE, HIGH, LOW. The half counter hc counts 0..per_q-1. per_q is the period shadow register.
- Slot position: tooth slot k is missing when k >= TOOTH_COUNT-GAP_TEETH.
- IDLE:
  - Outputs: vr_out=0, tooth_num=0, gap=0, hc=0.
  - en=1 and period>=2: per_q<=period, rev<=1, go to HIGH (tooth 0). vr_out rises on the same edge, i.e. the cycle after en is first sampled high.
  - en=1 and period<2: stay in IDLE, cfg_err<=1.
- HIGH:
  - vr_out=1, or 0 if the slot is missing.
  - hc increments each clk. At hc==per_q-1: hc<=0, go to LOW, vr_out<=0.
- LOW:
  - vr_out=0.
  - At hc==per_q-1: hc<=0. Advance tooth_num, wrapping TOOTH_COUNT-1 -> 0. Relatch per_q<=period.
  - If the new tooth is 0: rev<=1 for one clk.
  - If the relatched period is <2: go to IDLE with cfg_err<=1. Otherwise go to HIGH.
  - vr_out<=1 on that edge unless the new slot is missing.
- Timing figures:
  - One tooth = 2*per_q clks; one revolution = 2*per_q*TOOTH_COUNT clks.
  - vr_out duty is exactly per_q high, per_q low per present tooth.
  - Low time across the gap = per_q + 2*per_q*GAP_TEETH.
- Output timing: gap and tooth_num are registered and update on the same edge as the slot change.
- Period change mid-tooth: ignored until the next tooth boundary. No glitch and no partial tooth.
- en deasserted in any state: next edge goes to IDLE, vr_out=0, tooth_num=0, rev=0. Re-enable restarts at tooth 0, HIGH phase.
- en and slot boundary on the same edge: en=0 wins; no rev pulse.
- cfg_err is cleared on the edge where a valid start or relatch occurs, or when en=0.
- Counter width: the comparison is done at PERIOD_W bits. period=2^PERIOD_W-1 is legal; hc must never overflow.
- Mid-operation reset: outputs drop to 0 asynchronously. Operation resumes from IDLE after reset release.

Test Plan:
1. Nominal wheel: rst released, period=5, en=1.
   - vr_out first rises 1 clk after en. Each tooth is 5 high / 5 low.
   - 58 pulses per rev. Gap low time is 25 clks.
   - rev pulses every 600 clks. tooth_num runs 0..59 and wraps.
   - gap=1 exactly for tooth_num 58 and 59.
2. Period change: running at period=5, set period=8 midway through tooth 10.
   - Tooth 10 stays 5/5. Tooth 11 onward is 8/8.
   - The following revolution lasts 960 clks.
3. Stop/restart: en=0 during the HIGH phase of tooth 30.
   - Next clk: vr_out=0, tooth_num=0, no rev.
   - en=1 again: rev pulse and tooth 0 HIGH one clk later.
4. Config error:
   - period=1, en=1 -> stays IDLE, cfg_err=1, vr_out=0.
   - Set period=3 -> wheel starts, cfg_err=0.
   - Then period=0 while running -> IDLE at the next tooth boundary with cfg_err=1.
5. Async reset mid-gap: assert rst=0 between clk edges during tooth 59.
   - All outputs are 0 immediately, without waiting for a clk edge.
   - After release with en=1: restart at tooth 0 with a rev pulse.
6. Loopback: connect vr_out to hwag vr_in with period=50.
   - The hwag tooth counter must track tooth_num and detect the gap once per 6000 clks.
